// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage sitting directly upstream of a
//                1-cycle registered-read instruction memory. Owns the program
//                counter, tracks the single read in flight, and presents each
//                instruction with its pc to decode over a valid/ready
//                handshake. Handles decode backpressure, branch/jump
//                redirects and start/halt of program execution.
//  Ports       : clk, rst_n (async, active-low)
//                start                       - begin/restart at RESET_PC
//                imem_pc    -> memory        - read address
//                imem_data  <- memory        - word read at previous edge
//                if_valid/if_instr/if_pc     - to decode
//                id_ready   <- decode        - fire = if_valid & id_ready
//                redirect/br_target          - branch/jump taken
//                halted                      - program finished
//                fetch_err                   - sticky bad redirect target
//                perf_fetched/perf_stall     - only with FETCH_PERF_EN
//  Config      : define FETCH_PERF_EN to add fire/stall performance counters
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int         MEM_DEPTH = 1000,
    parameter logic [9:0] RESET_PC  = 10'd0,
    parameter logic [9:0] LAST_PC   = 10'd8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [9:0]  imem_pc,
    input  logic [31:0] imem_data,
    output logic        if_valid,
    input  logic        id_ready,
    output logic [31:0] if_instr,
    output logic [9:0]  if_pc,
    input  logic        redirect,
    input  logic [9:0]  br_target,
    output logic        halted,
    output logic        fetch_err
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0] perf_fetched,
    output logic [15:0] perf_stall
`endif
);

    // Highest legal pc; wrap happens here rather than at 1023.
    localparam logic [9:0] PC_MAX = 10'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nx;

    logic [9:0] pc_q;       // next address to issue
    logic [9:0] pc_d1;      // address of the read currently in flight
    logic       d1_v;       // read in flight is valid

    logic       run;
    logic       issue;
    logic       fire;
    logic       halt_fire;
    logic       leave;
    logic       target_ok;
    logic [9:0] pc_inc;

    assign run       = (state == S_RUN);
    assign issue     = run & ~redirect & (~d1_v | id_ready);
    assign if_valid  = run & d1_v & ~redirect;
    assign fire      = if_valid & id_ready;
    assign halt_fire = fire & (pc_d1 == LAST_PC);
    // start only has effect from IDLE or HALT.
    assign leave     = start & ~run;
    assign target_ok = (br_target <= PC_MAX);
    assign pc_inc    = (pc_q == PC_MAX) ? 10'd0 : pc_q + 10'd1;

    // When not issuing, re-read the presented address so imem_data stays
    // stable through a stall without needing a skid buffer.
    assign imem_pc   = issue ? pc_q : pc_d1;
    assign if_pc     = pc_d1;
    assign if_instr  = imem_data;
    assign halted    = (state == S_HALT);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start)     state_nx = S_RUN;
            S_RUN:   if (halt_fire) state_nx = S_HALT;
            S_HALT:  if (start)     state_nx = S_RUN;
            default:                state_nx = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // PC / in-flight tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            pc_d1     <= RESET_PC;
            d1_v      <= 1'b0;
            fetch_err <= 1'b0;
        end else if (leave) begin
            pc_q      <= RESET_PC;
            d1_v      <= 1'b0;
            fetch_err <= 1'b0;
        end else if (run) begin
            if (redirect) begin
                d1_v <= 1'b0;
                if (target_ok) begin
                    pc_q <= br_target;
                end else begin
                    pc_q      <= 10'd0;
                    fetch_err <= 1'b1;
                end
            end else if (halt_fire) begin
                // The fetch past LAST_PC issued this cycle is dropped.
                d1_v <= 1'b0;
            end else if (issue) begin
                pc_d1 <= pc_q;
                d1_v  <= 1'b1;
                pc_q  <= pc_inc;
            end else if (fire) begin
                d1_v <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_EN
    // ------------------------------------------------------------------
    // Saturating performance counters, cleared when execution starts
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= 16'd0;
            perf_stall   <= 16'd0;
        end else if (leave) begin
            perf_fetched <= 16'd0;
            perf_stall   <= 16'd0;
        end else begin
            if (fire && (perf_fetched != 16'hFFFF)) begin
                perf_fetched <= perf_fetched + 16'd1;
            end
            if (if_valid && !id_ready && (perf_stall != 16'hFFFF)) begin
                perf_stall <= perf_stall + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit. Instance a uses
//                default parameters; instance b uses RESET_PC=998, LAST_PC=1
//                to exercise pc wrap. Each has a 1-cycle registered memory
//                returning {22'h0, addr}.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, id_ready, redirect;
    logic [9:0]  br_target;
    logic [9:0]  imem_pc, if_pc;
    logic [31:0] imem_data, if_instr;
    logic        if_valid, halted, fetch_err;

    logic        start_b;
    logic [9:0]  imem_pc_b, if_pc_b;
    logic [31:0] imem_data_b, if_instr_b;
    logic        if_valid_b, halted_b, fetch_err_b;

`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetched, perf_stall, perf_fetched_b, perf_stall_b;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) imem_data   <= {22'h0, imem_pc};
    always @(posedge clk) imem_data_b <= {22'h0, imem_pc_b};

    fetch_unit u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_pc(imem_pc), .imem_data(imem_data),
        .if_valid(if_valid), .id_ready(id_ready),
        .if_instr(if_instr), .if_pc(if_pc),
        .redirect(redirect), .br_target(br_target),
        .halted(halted), .fetch_err(fetch_err)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
    );

    fetch_unit #(.RESET_PC(10'd998), .LAST_PC(10'd1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b),
        .imem_pc(imem_pc_b), .imem_data(imem_data_b),
        .if_valid(if_valid_b), .id_ready(1'b1),
        .if_instr(if_instr_b), .if_pc(if_pc_b),
        .redirect(1'b0), .br_target(10'd0),
        .halted(halted_b), .fetch_err(fetch_err_b)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched_b), .perf_stall(perf_stall_b)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 2 time units
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_pc(input logic [9:0] p);
        logic found;
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            if (if_valid && if_pc == p) found = 1'b1;
            else tick();
        end
        check_eq("wait_pc", {31'd0, found}, 32'd1);
    endtask

    task automatic run_to_halt(output int fires);
        fires = 0;
        for (int n = 0; n < 60 && !halted; n++) begin
            if (if_valid && id_ready) fires++;
            tick();
        end
        check_eq("halt_reached", {31'd0, halted}, 32'd1);
    endtask

    int exp_pc, first_c, last_c, fires, vcount, idx;
    logic [9:0] wrap_seq [4];

    initial begin
        rst_n = 1'b0; start = 1'b0; start_b = 1'b0;
        id_ready = 1'b1; redirect = 1'b0; br_target = 10'd0;
        wrap_seq[0] = 10'd998; wrap_seq[1] = 10'd999;
        wrap_seq[2] = 10'd0;   wrap_seq[3] = 10'd1;
        #12;
        // Reset state
        check_eq("rst_valid",   {31'd0, if_valid},  32'd0);
        check_eq("rst_halted",  {31'd0, halted},    32'd0);
        check_eq("rst_imem_pc", {22'd0, imem_pc},   32'd0);
        check_eq("rst_if_pc",   {22'd0, if_pc},     32'd0);
        check_eq("rst_err",     {31'd0, fetch_err}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        tick(); tick();
        check_eq("idle_valid", {31'd0, if_valid}, 32'd0);

        // T1 basic run
        do_start();
        check_eq("t1_first_imem_pc", {22'd0, imem_pc}, 32'd0);
        exp_pc = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 20; c++) begin
            if (if_valid && id_ready) begin
                check_eq("t1_pc",    {22'd0, if_pc}, exp_pc);
                check_eq("t1_instr", if_instr, exp_pc);
                if (first_c < 0) first_c = c;
                last_c = c;
                exp_pc++;
            end
            tick();
        end
        check_eq("t1_fires",       exp_pc, 9);
        check_eq("t1_consecutive", last_c - first_c, 8);
        check_eq("t1_first_lat",   first_c, 1);
        check_eq("t1_halted",      {31'd0, halted}, 32'd1);
        check_eq("t1_halt_valid",  {31'd0, if_valid}, 32'd0);
`ifdef FETCH_PERF_EN
        check_eq("t1_perf_fetched", {16'd0, perf_fetched}, 32'd9);
`endif

        // T2 backpressure
        do_start();
        check_eq("t2_restart", {31'd0, halted}, 32'd0);
        wait_pc(10'd3);
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("t2_stall_valid", {31'd0, if_valid}, 32'd1);
            check_eq("t2_stall_pc",    {22'd0, if_pc},    32'd3);
            check_eq("t2_stall_instr", if_instr,          32'd3);
            check_eq("t2_stall_imem",  {22'd0, imem_pc},  32'd3);
            tick();
        end
        id_ready = 1'b1;
        #1;
        check_eq("t2_release_pc", {22'd0, if_pc}, 32'd3);
        tick();
        check_eq("t2_next4", {22'd0, if_pc}, 32'd4);
        check_eq("t2_next4_v", {31'd0, if_valid}, 32'd1);
        tick();
        check_eq("t2_next5", {22'd0, if_pc}, 32'd5);
        check_eq("t2_next5_i", if_instr, 32'd5);
`ifdef FETCH_PERF_EN
        check_eq("t2_perf_stall", {16'd0, perf_stall}, 32'd3);
`endif
        run_to_halt(fires);

        // T3 redirect
        do_start();
        wait_pc(10'd5);
        redirect = 1'b1; br_target = 10'd2;
        #1;
        check_eq("t3_squash0", {31'd0, if_valid}, 32'd0);
        tick();
        redirect = 1'b0;
        #1;
        check_eq("t3_squash1", {31'd0, if_valid}, 32'd0);
        tick();
        check_eq("t3_target_v",  {31'd0, if_valid}, 32'd1);
        check_eq("t3_target_pc", {22'd0, if_pc},    32'd2);
        check_eq("t3_target_i",  if_instr,          32'd2);
        run_to_halt(fires);
        check_eq("t3_fires_after", fires, 7);

        // T4 bad target
        do_start();
        wait_pc(10'd3);
        redirect = 1'b1; br_target = 10'd1000;
        #1;
        check_eq("t4_squash", {31'd0, if_valid}, 32'd0);
        tick();
        redirect = 1'b0;
        #1;
        check_eq("t4_err", {31'd0, fetch_err}, 32'd1);
        tick();
        check_eq("t4_pc0",   {22'd0, if_pc},    32'd0);
        check_eq("t4_pc0_v", {31'd0, if_valid}, 32'd1);
        run_to_halt(fires);
        check_eq("t4_fires_after", fires, 9);
        check_eq("t4_err_sticky", {31'd0, fetch_err}, 32'd1);
        // redirect while halted has no effect
        redirect = 1'b1; br_target = 10'd4;
        tick();
        redirect = 1'b0;
        check_eq("t4_halt_redir", {31'd0, halted}, 32'd1);
        do_start();
        check_eq("t4_err_clear", {31'd0, fetch_err}, 32'd0);

        // T6 async reset mid-RUN
        wait_pc(10'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_valid",   {31'd0, if_valid}, 32'd0);
        check_eq("t6_halted",  {31'd0, halted},   32'd0);
        check_eq("t6_imem_pc", {22'd0, imem_pc},  32'd0);
        @(negedge clk); rst_n = 1'b1;
        vcount = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (if_valid) vcount++;
        end
        check_eq("t6_no_valid", vcount, 0);
        do_start();
        tick();
        check_eq("t6_restart_pc", {22'd0, if_pc},    32'd0);
        check_eq("t6_restart_v",  {31'd0, if_valid}, 32'd1);

        // T5 wrap (instance b)
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        idx = 0;
        for (int c = 0; c < 15; c++) begin
            if (if_valid_b) begin
                if (idx < 4) check_eq("t5_seq", {22'd0, if_pc_b}, {22'd0, wrap_seq[idx]});
                idx++;
            end
            tick();
        end
        check_eq("t5_count",  idx, 4);
        check_eq("t5_halted", {31'd0, halted_b}, 32'd1);
`ifdef FETCH_PERF_EN
        check_eq("t5_perf_fetched", {16'd0, perf_fetched_b}, 32'd4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net: never hang.
    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
